see_cone_campaign: RTL and testbench

SEE_CONE_CAMPAIGN -- requirements
Module: see_cone_campaign

---
 rtl/see_cone_pkg.sv | 26 ++
 rtl/see_cone_campaign_vec_gen.sv | 39 +++
 rtl/see_cone_campaign.sv | 115 +++++++++++
 tb/tb_see_cone_campaign.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/see_cone_pkg.sv
// Shared types and constants for the SEE cone fault-injection campaign controller.
// Vector ordering is selected by the SEE_CONE_LFSR_EN macro (see see_vec_gen).
package see_cone_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } see_state_t;

    localparam int VEC_W_DEF = 8;
    localparam int CNT_W_DEF = VEC_W_DEF + 1;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;
    // State whose successor is the seed, i.e. the last state of a full period.
    localparam logic [7:0] LFSR_LAST = 8'h80;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/see_cone_campaign_vec_gen.sv
// Stimulus vector sequencer: ascending binary by default, or 0x00 followed by the
// 255 LFSR states when SEE_CONE_LFSR_EN is defined (VEC_W must be 8 in that build).
module see_vec_gen
    import see_cone_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [VEC_W-1:0] vec,
    output logic             last
);

    logic [VEC_W-1:0] vec_next;

`ifdef SEE_CONE_LFSR_EN
    // 0x00 is not an LFSR state, so it is emitted first and then hands over to the seed.
    always_comb begin
        vec_next = (vec == '0) ? LFSR_SEED : lfsr_next(vec);
        last     = (vec == LFSR_LAST);
    end
`else
    always_comb begin
        vec_next = vec + VEC_W'(1);
        last     = &vec;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            vec <= '0;
        end else if (advance) begin
            vec <= vec_next;
        end
    end

endmodule

// File: rtl/see_cone_campaign.sv
// Exhaustive single-fault campaign over a combinational cone: apply, settle, compare.
// Vector order: ascending, or LFSR order when SEE_CONE_LFSR_EN is defined.
module see_cone_campaign
    import see_cone_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int CNT_W = VEC_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       settle_cycles,
    output logic [VEC_W-1:0] vec_out,
    output logic             inject,
    input  logic             golden_in,
    input  logic             faulty_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [VEC_W-1:0] first_err_vec,
    output logic             first_err_valid,
    output see_state_t       dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy is high
    // from the following cycle through the last SAMPLE; done pulses for one cycle
    // in DONE (busy low), and the result outputs hold until the next accepted start.

    localparam logic [CNT_W-1:0] CNT_MAX = {{(CNT_W-1){1'b0}}, 1'b1} << VEC_W;

    see_state_t state, state_nxt;
    logic [3:0] settle_len;
    logic [3:0] settle_cnt;
    logic       start_acc;
    logic       gen_advance;
    logic       vec_last;
    logic       mismatch;

    see_vec_gen #(.VEC_W(VEC_W)) u_vec_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_acc),
        .advance (gen_advance),
        .vec     (vec_out),
        .last    (vec_last)
    );

    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        gen_advance = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY:  state_nxt = SETTLE;
            SETTLE: if (settle_cnt == 4'd0) state_nxt = SAMPLE;
            SAMPLE: begin
                if (vec_last) begin
                    state_nxt = DONE;
                end else begin
                    gen_advance = 1'b1;
                    state_nxt   = APPLY;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mismatch = (state == SAMPLE) && (golden_in != faulty_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_len      <= 4'd1;
            settle_cnt      <= 4'd0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                settle_len      <= (settle_cycles == 4'd0) ? 4'd1 : settle_cycles;
                err_count       <= '0;
                first_err_vec   <= '0;
                first_err_valid <= 1'b0;
            end
            // SETTLE exits when the counter reads zero, so load S-1 for S cycles.
            if (state == APPLY) begin
                settle_cnt <= settle_len - 4'd1;
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (mismatch) begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!first_err_valid) begin
                    first_err_vec   <= vec_out;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

    assign inject    = (state == APPLY);
    assign busy      = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_see_cone_campaign.sv
// Directed campaigns for see_cone_campaign with a done-triggered scoreboard.
module tb_see_cone_campaign;
    import see_cone_pkg::*;

    localparam int VEC_W = 8;
    localparam int CNT_W = 9;
    localparam int NVEC  = 256;
    localparam int EXP_W = 8 + CNT_W + VEC_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       settle_cycles = 4'd0;
    logic [VEC_W-1:0] vec_out;
    logic             inject;
    logic             golden_in;
    logic             faulty_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [VEC_W-1:0] first_err_vec;
    logic             first_err_valid;
    see_state_t       dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fault_mode = 0;
    int done_cnt = 0;

    // {period[7:0], err_count, first_err_vec, first_err_valid}
    logic [EXP_W-1:0] exp_q[$];

    see_cone_campaign #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .settle_cycles   (settle_cycles),
        .vec_out         (vec_out),
        .inject          (inject),
        .golden_in       (golden_in),
        .faulty_in       (faulty_in),
        .busy            (busy),
        .done            (done),
        .err_count       (err_count),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid),
        .dbg_state       (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cone models: golden is parity; faulty copy per fault_mode
    always_comb begin
        golden_in = ^vec_out;
        case (fault_mode)
            1:       faulty_in = (vec_out == 8'h2A) ? ~golden_in : golden_in;
            2:       faulty_in = ~golden_in;
            default: faulty_in = golden_in;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int s, input int e_err, input int e_fvec, input int e_fvalid);
        logic [7:0]       per;
        logic [CNT_W-1:0] er;
        logic [VEC_W-1:0] fv;
        logic             fva;
        per = 8'(((s == 0) ? 1 : s) + 2);
        er  = CNT_W'(e_err);
        fv  = VEC_W'(e_fvec);
        fva = (e_fvalid != 0);
        exp_q.push_back({per, er, fv, fva});
    endtask

    task automatic issue(input int s, input int mode);
        settle_cycles = 4'(s);
        fault_mode    = mode;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vec_out"}, vec_out, 0);
        check({tag, "_inject"}, inject, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_err_vec"}, first_err_vec, 0);
        check({tag, "_first_err_valid"}, first_err_valid, 0);
    endtask

    // Monitor / scoreboard
    int               vec_idx = 0;
    int               t_apply0 = 0;
    int               t_last = 0;
    int               period = 0;
    logic [EXP_W-1:0] e;
    bit               seen[NVEC];
`ifdef SEE_CONE_LFSR_EN
    logic [7:0]       first4[4] = '{8'h00, 8'h01, 8'h02, 8'h04};
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            vec_idx = 0;
        end else begin
            if (err_count > CNT_W'(NVEC)) begin
                failures++;
                $display("FAIL err_count_saturation: got %0d limit %0d", err_count, NVEC);
            end
            if (inject) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_apply: got vec 0x%0h expected no campaign", vec_out);
                end else begin
                    e      = exp_q[0];
                    period = int'(e[EXP_W-1 -: 8]);
                    if (vec_idx == 0) begin
                        t_apply0 = cyc;
                        for (int i = 0; i < NVEC; i++) seen[i] = 1'b0;
                    end else begin
                        check("vector_period", cyc - t_last, period);
                    end
`ifdef SEE_CONE_LFSR_EN
                    if (vec_idx < 4) check("lfsr_first_vectors", vec_out, first4[vec_idx]);
`else
                    check("ascending_vector", vec_out, vec_idx);
`endif
                    if (seen[vec_out]) begin
                        failures++;
                        $display("FAIL duplicate_vector: got 0x%0h again expected unique", vec_out);
                    end
                    seen[vec_out] = 1'b1;
                    t_last = cyc;
                    vec_idx++;
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    e      = exp_q.pop_front();
                    period = int'(e[EXP_W-1 -: 8]);
                    check("err_count", err_count, e[CNT_W+VEC_W:VEC_W+1]);
                    check("first_err_vec", first_err_vec, e[VEC_W:1]);
                    check("first_err_valid", first_err_valid, e[0]);
                    check("campaign_length", cyc - t_apply0, NVEC * period);
                    check("vector_count", vec_idx, NVEC);
                    check("busy_low_at_done", busy, 0);
                end
                vec_idx = 0;
            end
        end
    end

    // Driver
    int dc;
    int n;
    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Fault-free, S=2: 4 cycles per vector, 1024 total
        push_exp(2, 0, 0, 0);
        issue(2, 0);
        wait_done(3000);
        tick();

        // S=0 behaves as S=1; single mismatch at 0x2A
        push_exp(0, 1, 'h2A, 1);
        issue(0, 1);
        wait_done(3000);
        repeat (10) tick();
        check("hold_err_count", err_count, 1);
        check("hold_first_err_vec", first_err_vec, 8'h2A);
        check("hold_first_err_valid", first_err_valid, 1);

        // Permanently inverted faulty copy
        push_exp(5, 256, 0, 1);
        issue(5, 2);
        wait_done(3000);

        // start during DONE is ignored, start the cycle after is accepted
        push_exp(0, 256, 0, 1);
        settle_cycles = 4'd0;
        fault_mode    = 2;
        start         = 1'b1;
        tick();
        check("start_at_done_busy", busy, 0);
        check("start_at_done_err_held", err_count, 256);
        tick();
        start = 1'b0;
        check("start_after_done_busy", busy, 1);
        check("start_after_done_err_cleared", err_count, 0);
        wait_done(3000);
        tick();

        // Extra start mid-campaign, then reset abort at vector 100
        push_exp(1, 0, 0, 0);
        issue(1, 0);
        n = 0;
        while (!(inject && vec_out == 8'd10) && n < 200) begin
            tick();
            n++;
        end
        check("reach_vector_10", vec_out, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (vec_out != 8'd100 && n < 1000) begin
            tick();
            n++;
        end
        check("reach_vector_100", vec_out, 100);
        dc    = done_cnt;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        check_zero_outputs("abort");
        repeat (20) tick();
        check("abort_no_done", done_cnt, dc);
        check("abort_idle_busy", busy, 0);

        // Clean campaign after abort, S=3
        push_exp(3, 1, 'h2A, 1);
        issue(3, 1);
        wait_done(3000);
        tick();
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
